neighbor_table_writer: RTL and testbench

- Writer side of the shared neighbor table in the 16-bit-word data memory; the routing-decision blocks only read this table.
- On each received neighbor beacon it looks up the sender's ID among the stored neighbors and refreshes its cluster, battery and Q-value. A sender that is not yet stored is appended and neighborCount is incremented.
- It drives the memory port through its own lane of the address mux, and it owns wr_en while active.

---
 rtl/neighbor_table_writer_if.sv | 24 ++
 rtl/neighbor_table_writer.sv | 170 +++++++++++++++++
 tb/tb_neighbor_table_writer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_table_writer_if.sv
// Memory port of the neighbor table writer: byte address, write strobe and
// data in both directions, with read data returned one clock after the address.
interface neighbor_table_writer_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;

  modport master (
    output address,
    output wr_en,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  address,
    input  wr_en,
    input  mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/neighbor_table_writer.sv
// Writer of the shared neighbor table: finds the beacon sender among the stored
// IDs and refreshes its fields, or appends it and bumps neighborCount last.
module neighbor_table_writer #(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    MAX_NEIGHBORS = 64,
  parameter logic [WORD_WIDTH-1:0] NID_BASE      = 16'h0048,
  parameter logic [WORD_WIDTH-1:0] CID_BASE      = 16'h00C8,
  parameter logic [WORD_WIDTH-1:0] BAT_BASE      = 16'h0148,
  parameter logic [WORD_WIDTH-1:0] QV_BASE       = 16'h01C8,
  parameter logic [WORD_WIDTH-1:0] CNT_ADDR      = 16'h068A
) (
  input  logic                               clock,
  input  logic                               nrst,
  // start/done level handshake: start is held high with the pkt fields stable;
  // done rises when the operation ends and stays high until start drops.
  input  logic                               start,
  input  logic [WORD_WIDTH-1:0]              pkt_nid,
  input  logic [WORD_WIDTH-1:0]              pkt_cid,
  input  logic [WORD_WIDTH-1:0]              pkt_bat,
  input  logic [WORD_WIDTH-1:0]              pkt_qv,
  neighbor_table_writer_if.master            mem,
  output logic [$clog2(MAX_NEIGHBORS)-1:0]   entry_index,
  output logic                               is_new,
  output logic                               table_full,
  output logic                               done,
  output logic [3:0]                         dbg_state
);
  localparam int IW = $clog2(MAX_NEIGHBORS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NEIGHBORS);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, CAP_CNT, RD_ID, CMP_ID,
    WR_NID, WR_CID, WR_BAT, WR_QV, WR_CNT, DONE
  } state_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] nid_q, cid_q, bat_q, qv_q;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         i, idx;
  logic                  is_new_q, full_q;

  logic [CW-1:0]         cnt_cap, i_next;
  logic                  id_match;
  logic [WORD_WIDTH-1:0] i_off, idx_off, cnt_inc;

  // A corrupted count above capacity is clamped so the scan stays in the table.
  assign cnt_cap  = (mem.mem_data_out > WORD_WIDTH'(MAX_NEIGHBORS)) ? MAX_CNT
                                                                     : mem.mem_data_out[CW-1:0];
  assign i_next   = {1'b0, i} + CW'(1);
  assign id_match = (mem.mem_data_out == nid_q);
  assign i_off    = WORD_WIDTH'({i, 1'b0});
  assign idx_off  = WORD_WIDTH'({idx, 1'b0});
  assign cnt_inc  = WORD_WIDTH'(cnt) + WORD_WIDTH'(1);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      nid_q    <= '0;
      cid_q    <= '0;
      bat_q    <= '0;
      qv_q     <= '0;
      cnt      <= '0;
      i        <= '0;
      idx      <= '0;
      is_new_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          nid_q <= pkt_nid;
          cid_q <= pkt_cid;
          bat_q <= pkt_bat;
          qv_q  <= pkt_qv;
        end
        CAP_CNT: begin
          cnt <= cnt_cap;
          i   <= '0;
          if (cnt_cap == '0) begin
            idx      <= '0;
            is_new_q <= 1'b1;
          end
        end
        CMP_ID: begin
          if (id_match) begin
            idx      <= i;
            is_new_q <= 1'b0;
          end else if (i_next < cnt) begin
            i <= i_next[IW-1:0];
          end else if (cnt < MAX_CNT) begin
            idx      <= cnt[IW-1:0];
            is_new_q <= 1'b1;
          end else begin
            full_q <= 1'b1;
          end
        end
        DONE: if (!start) begin
          is_new_q <= 1'b0;
          full_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n         = state;
    mem.address     = '0;
    mem.wr_en       = 1'b0;
    mem.mem_data_in = '0;
    case (state)
      IDLE:    if (start) state_n = RD_CNT;
      RD_CNT: begin
        mem.address = CNT_ADDR;
        state_n     = CAP_CNT;
      end
      CAP_CNT: state_n = (cnt_cap == '0) ? WR_NID : RD_ID;
      RD_ID: begin
        mem.address = NID_BASE + i_off;
        state_n     = CMP_ID;
      end
      CMP_ID: begin
        if (id_match)            state_n = WR_CID;
        else if (i_next < cnt)   state_n = RD_ID;
        else if (cnt < MAX_CNT)  state_n = WR_NID;
        else                     state_n = DONE;
      end
      WR_NID: begin
        mem.address     = NID_BASE + idx_off;
        mem.wr_en       = 1'b1;
        mem.mem_data_in = nid_q;
        state_n         = WR_CID;
      end
      WR_CID: begin
        mem.address     = CID_BASE + idx_off;
        mem.wr_en       = 1'b1;
        mem.mem_data_in = cid_q;
        state_n         = WR_BAT;
      end
      WR_BAT: begin
        mem.address     = BAT_BASE + idx_off;
        mem.wr_en       = 1'b1;
        mem.mem_data_in = bat_q;
        state_n         = WR_QV;
      end
      WR_QV: begin
        mem.address     = QV_BASE + idx_off;
        mem.wr_en       = 1'b1;
        mem.mem_data_in = qv_q;
        state_n         = is_new_q ? WR_CNT : DONE;
      end
      // The count goes last so readers never see a half-written entry.
      WR_CNT: begin
        mem.address     = CNT_ADDR;
        mem.wr_en       = 1'b1;
        mem.mem_data_in = cnt_inc;
        state_n         = DONE;
      end
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign entry_index = idx;
  assign is_new      = is_new_q;
  assign table_full  = full_q;
  assign done        = (state == DONE);
  assign dbg_state   = state;
endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed bench for neighbor_table_writer: word memory model with one-cycle
// read latency, write log, and per-scenario checks of writes, flags and latency.
module tb_neighbor_table_writer;
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic        clock = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] pkt_nid, pkt_cid, pkt_bat, pkt_qv;
  logic [5:0]  entry_index;
  logic        is_new, table_full, done;
  logic [3:0]  dbg_state;

  neighbor_table_writer_if #(.WORD_WIDTH(16)) bus ();

  neighbor_table_writer dut (
    .clock       (clock),
    .nrst        (nrst),
    .start       (start),
    .pkt_nid     (pkt_nid),
    .pkt_cid     (pkt_cid),
    .pkt_bat     (pkt_bat),
    .pkt_qv      (pkt_qv),
    .mem         (bus.master),
    .entry_index (entry_index),
    .is_new      (is_new),
    .table_full  (table_full),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock/reset
  always #5 clock = ~clock;

  // memory model and write log
  logic [15:0] mem_arr [0:2047];
  logic [15:0] wa_q[$], wd_q[$];
  logic [15:0] ea[$], ed[$];

  always @(posedge clock) begin
    bus.mem_data_out <= mem_arr[bus.address[11:1]];
    if (bus.wr_en) begin
      mem_arr[bus.address[11:1]] = bus.mem_data_in;
      wa_q.push_back(bus.address);
      wd_q.push_back(bus.mem_data_in);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // driver tasks
  task automatic clear_mem();
    for (int a = 0; a < 2048; a++) mem_arr[a] = 16'h0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic put_word(input logic [15:0] addr, input logic [15:0] val);
    mem_arr[addr[11:1]] = val;
  endtask

  task automatic begin_op(input logic [15:0] nid, input logic [15:0] cid,
                          input logic [15:0] bat, input logic [15:0] qv);
    @(negedge clock);
    pkt_nid = nid;
    pkt_cid = cid;
    pkt_bat = bat;
    pkt_qv  = qv;
    start   = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
      if (done) break;
    end
  endtask

  task automatic end_op();
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clock);
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.address !== 16'h0) $display("FAIL reset_address: got %h want 0000", bus.address); else n_pass++;
    n_checks++; if ({done, is_new, table_full} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {done, is_new, table_full}); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    nrst = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_empty_append();
    clear_mem();
    begin_op(16'd5, 16'd1, 16'd80, 16'd12);
    wait_done(300, cyc);
    n_checks++; if (cyc != 8) $display("FAIL empty_latency: got %0d want 8", cyc); else n_pass++;
    ea = '{16'h0048, 16'h00C8, 16'h0148, 16'h01C8, 16'h068A};
    ed = '{16'd5, 16'd1, 16'd80, 16'd12, 16'd1};
    n_checks++; if (wa_q.size() != ea.size()) $display("FAIL empty_nwrites: got %0d want %0d", wa_q.size(), ea.size()); else n_pass++;
    foreach (ea[k]) begin
      n_checks++;
      if (k >= wa_q.size() || wa_q[k] !== ea[k] || wd_q[k] !== ed[k])
        $display("FAIL empty_write%0d: got %h=%h want %h=%h", k,
                 (k < wa_q.size()) ? wa_q[k] : 16'hxxxx, (k < wd_q.size()) ? wd_q[k] : 16'hxxxx, ea[k], ed[k]);
      else n_pass++;
    end
    n_checks++; if (entry_index !== 6'd0) $display("FAIL empty_index: got %0d want 0", entry_index); else n_pass++;
    n_checks++; if (is_new !== 1'b1 || table_full !== 1'b0) $display("FAIL empty_flags: got new=%b full=%b want 1 0", is_new, table_full); else n_pass++;
  endtask

  task automatic test_hold_and_second();
    repeat (5) @(negedge clock);
    n_checks++; if (wa_q.size() != 5) $display("FAIL hold_no_rerun: got %0d writes want 5", wa_q.size()); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL hold_done: got %b want 1", done); else n_pass++;
    end_op();
    n_checks++; if (done !== 1'b0 || is_new !== 1'b0) $display("FAIL release_flags: got done=%b new=%b want 0 0", done, is_new); else n_pass++;
    wa_q.delete();
    wd_q.delete();
    begin_op(16'd6, 16'd4, 16'd60, 16'd3);
    wait_done(300, cyc);
    n_checks++; if (cyc != 10) $display("FAIL second_latency: got %0d want 10", cyc); else n_pass++;
    ea = '{16'h004A, 16'h00CA, 16'h014A, 16'h01CA, 16'h068A};
    ed = '{16'd6, 16'd4, 16'd60, 16'd3, 16'd2};
    n_checks++; if (wa_q.size() != ea.size()) $display("FAIL second_nwrites: got %0d want %0d", wa_q.size(), ea.size()); else n_pass++;
    foreach (ea[k]) begin
      n_checks++;
      if (k >= wa_q.size() || wa_q[k] !== ea[k] || wd_q[k] !== ed[k])
        $display("FAIL second_write%0d: got %h=%h want %h=%h", k,
                 (k < wa_q.size()) ? wa_q[k] : 16'hxxxx, (k < wd_q.size()) ? wd_q[k] : 16'hxxxx, ea[k], ed[k]);
      else n_pass++;
    end
    n_checks++; if (entry_index !== 6'd1 || is_new !== 1'b1) $display("FAIL second_entry: got idx=%0d new=%b want 1 1", entry_index, is_new); else n_pass++;
    end_op();
  endtask

  task automatic test_update();
    clear_mem();
    put_word(16'h068A, 16'd3);
    put_word(16'h0048, 16'd2);
    put_word(16'h004A, 16'd5);
    put_word(16'h004C, 16'd9);
    begin_op(16'd9, 16'd3, 16'd40, 16'd7);
    wait_done(300, cyc);
    n_checks++; if (cyc != 12) $display("FAIL update_latency: got %0d want 12", cyc); else n_pass++;
    ea = '{16'h00CC, 16'h014C, 16'h01CC};
    ed = '{16'd3, 16'd40, 16'd7};
    n_checks++; if (wa_q.size() != ea.size()) $display("FAIL update_nwrites: got %0d want %0d", wa_q.size(), ea.size()); else n_pass++;
    foreach (ea[k]) begin
      n_checks++;
      if (k >= wa_q.size() || wa_q[k] !== ea[k] || wd_q[k] !== ed[k])
        $display("FAIL update_write%0d: got %h=%h want %h=%h", k,
                 (k < wa_q.size()) ? wa_q[k] : 16'hxxxx, (k < wd_q.size()) ? wd_q[k] : 16'hxxxx, ea[k], ed[k]);
      else n_pass++;
    end
    n_checks++; if (entry_index !== 6'd2 || is_new !== 1'b0) $display("FAIL update_entry: got idx=%0d new=%b want 2 0", entry_index, is_new); else n_pass++;
    end_op();
    n_checks++; if (entry_index !== 6'd2) $display("FAIL index_kept: got %0d want 2", entry_index); else n_pass++;
  endtask

  task automatic test_full(input logic [15:0] stored_cnt, input bit at_last);
    clear_mem();
    put_word(16'h068A, stored_cnt);
    for (int j = 0; j < 64; j++) put_word(16'h0048 + 16'(2 * j), 16'(200 + j));
    if (at_last) put_word(16'h0046 + 16'd128, 16'd100);
    begin_op(16'd100, 16'd8, 16'd20, 16'd30);
    wait_done(300, cyc);
    if (at_last) begin
      n_checks++; if (cyc != 134) $display("FAIL last_latency: got %0d want 134", cyc); else n_pass++;
      ea = '{16'h0146, 16'h01C6, 16'h0246};
      ed = '{16'd8, 16'd20, 16'd30};
      n_checks++; if (wa_q.size() != ea.size()) $display("FAIL last_nwrites: got %0d want %0d", wa_q.size(), ea.size()); else n_pass++;
      foreach (ea[k]) begin
        n_checks++;
        if (k >= wa_q.size() || wa_q[k] !== ea[k] || wd_q[k] !== ed[k])
          $display("FAIL last_write%0d: got %h=%h want %h=%h", k,
                   (k < wa_q.size()) ? wa_q[k] : 16'hxxxx, (k < wd_q.size()) ? wd_q[k] : 16'hxxxx, ea[k], ed[k]);
        else n_pass++;
      end
      n_checks++; if (table_full !== 1'b0 || entry_index !== 6'd63) $display("FAIL last_entry: got full=%b idx=%0d want 0 63", table_full, entry_index); else n_pass++;
    end else begin
      n_checks++; if (cyc != 131) $display("FAIL full_latency cnt=%0d: got %0d want 131", stored_cnt, cyc); else n_pass++;
      n_checks++; if (wa_q.size() != 0) $display("FAIL full_nwrites cnt=%0d: got %0d want 0", stored_cnt, wa_q.size()); else n_pass++;
      n_checks++; if (table_full !== 1'b1 || done !== 1'b1) $display("FAIL full_flags cnt=%0d: got full=%b done=%b want 1 1", stored_cnt, table_full, done); else n_pass++;
      n_checks++; if (mem_arr[16'h068A >> 1] !== stored_cnt) $display("FAIL full_count_word: got %h want %h", mem_arr[16'h068A >> 1], stored_cnt); else n_pass++;
    end
    end_op();
    n_checks++; if (table_full !== 1'b0) $display("FAIL full_clear: got %b want 0", table_full); else n_pass++;
  endtask

  task automatic test_duplicate();
    clear_mem();
    put_word(16'h068A, 16'd3);
    put_word(16'h0048, 16'd7);
    put_word(16'h004A, 16'd3);
    put_word(16'h004C, 16'd7);
    begin_op(16'd7, 16'd11, 16'd22, 16'd33);
    wait_done(300, cyc);
    n_checks++; if (cyc != 8) $display("FAIL dup_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++;
    if (wa_q.size() != 3 || wa_q[0] !== 16'h00C8 || wa_q[1] !== 16'h0148 || wa_q[2] !== 16'h01C8)
      $display("FAIL dup_writes: got %0d writes first=%h want 3 first=00c8", wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 16'hxxxx);
    else n_pass++;
    n_checks++; if (entry_index !== 6'd0 || is_new !== 1'b0) $display("FAIL dup_entry: got idx=%0d new=%b want 0 0", entry_index, is_new); else n_pass++;
    end_op();
  endtask

  task automatic test_reset_mid_write();
    clear_mem();
    begin_op(16'd11, 16'd2, 16'd50, 16'd9);
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.wr_en !== 1'b1 || bus.address !== 16'h0148) $display("FAIL midrst_pre: got we=%b addr=%h want 1 0148", bus.wr_en, bus.address); else n_pass++;
    nrst = 1'b0;
    #1;
    n_checks++; if (bus.wr_en !== 1'b0 || bus.address !== 16'h0 || bus.mem_data_in !== 16'h0) $display("FAIL midrst_bus: got we=%b addr=%h data=%h want 0", bus.wr_en, bus.address, bus.mem_data_in); else n_pass++;
    n_checks++; if ({done, is_new, table_full} !== 3'b000 || entry_index !== 6'd0) $display("FAIL midrst_flags: got %b idx=%0d want 000 0", {done, is_new, table_full}, entry_index); else n_pass++;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    nrst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (dbg_state !== ST_IDLE || done !== 1'b0) $display("FAIL midrst_idle: got state=%0d done=%b want 0 0", dbg_state, done); else n_pass++;
    n_checks++; if (wa_q.size() != 2) $display("FAIL midrst_nwrites: got %0d want 2", wa_q.size()); else n_pass++;
    n_checks++; if (mem_arr[16'h068A >> 1] !== 16'h0) $display("FAIL midrst_count: got %h want 0000", mem_arr[16'h068A >> 1]); else n_pass++;
  endtask

  initial begin
    nrst    = 1'b0;
    start   = 1'b0;
    pkt_nid = '0;
    pkt_cid = '0;
    pkt_bat = '0;
    pkt_qv  = '0;
    clear_mem();
    test_reset();
    test_empty_append();
    test_hold_and_second();
    test_update();
    test_full(16'd64, 1'b0);
    test_full(16'd64, 1'b1);
    test_full(16'd200, 1'b0);
    test_duplicate();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
